// File: rtl/tx_fifo_ctrl_pkg.sv
// Shared UART system package: TX drain FSM encoding and default timeout.
package tx_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_TX_WAIT   = 2'd2,
    ST_GAP       = 2'd3
  } tx_state_e;

  localparam int TO_CYCLES_DEF = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tx_fifo_ctrl.sv
// Drains an async FIFO read side into a UART transmitter, one byte per frame,
// with a configurable inter-frame gap and a sticky load-acknowledge timeout.
module tx_fifo_ctrl
  import tx_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_WIDTH  = 4,
  parameter int TO_CYCLES  = TO_CYCLES_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic [GAP_WIDTH-1:0]  GAP_CFG,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  output logic                  FIFO_R_INC,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_DATA_VALID,
  input  logic                  ERR_CLR,
  output logic                  TO_ERR,
  output logic [7:0]            FRAME_CNT
);

  // One down-counter serves both the LOAD_WAIT timeout and the GAP length.
  localparam int CNT_W = max_int(GAP_WIDTH, $clog2(TO_CYCLES + 1));
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TO_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  tx_state_e              state_q;
  tx_state_e              state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic                   strobe_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   to_err_q;
  logic [7:0]             frame_cnt_q;

  logic                   start;
  logic                   timeout;
  logic                   frame_done;
  logic                   gap_nz;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD_WAIT;
      end
      ST_LOAD_WAIT: begin
        if (TX_BUSY)            state_d = ST_TX_WAIT;
        else if (cnt_q == '0)   state_d = ST_IDLE;
      end
      ST_TX_WAIT: begin
        if (!TX_BUSY) state_d = gap_nz ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gap_nz     = |GAP_CFG;
    start      = (state_q == ST_IDLE) && EN && !FIFO_EMPTY && !TX_BUSY;
    timeout    = (state_q == ST_LOAD_WAIT) && !TX_BUSY && (cnt_q == '0);
    frame_done = (state_q == ST_TX_WAIT) && !TX_BUSY;
  end

  // Pop and load leave the same flop, so they can never separate; the byte is
  // registered on the same edge so the transmitter sees data with its strobe.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      strobe_q <= 1'b0;
      data_q   <= '0;
    end else begin
      strobe_q <= start;
      if (start) data_q <= FIFO_RD_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= TO_LOAD;
    end else begin
      unique case (state_q)
        ST_LOAD_WAIT: begin
          if (TX_BUSY)            cnt_q <= '0;
          else if (cnt_q != '0)   cnt_q <= cnt_q - CNT_ONE;
        end
        ST_TX_WAIT: begin
          if (frame_done && gap_nz) cnt_q <= CNT_W'(GAP_CFG) - CNT_ONE;
        end
        ST_GAP: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_ONE;
        end
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // A timeout raised in the same cycle as a clear request takes priority.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      to_err_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (timeout)      to_err_q <= 1'b1;
      else if (ERR_CLR) to_err_q <= 1'b0;
      if (frame_done)   frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign FIFO_R_INC    = strobe_q;
  assign TX_DATA_VALID = strobe_q;
  assign TX_P_DATA     = data_q;
  assign TO_ERR        = to_err_q;
  assign FRAME_CNT     = frame_cnt_q;

endmodule

// File: doc/tx_fifo_ctrl.md
TX_FIFO_CTRL -- requirements
Module: tx_fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 8, width of the FIFO read data and the UART TX parallel data.
REQ-002 Parameter GAP_WIDTH, 4, width of the inter-frame gap configuration.
REQ-003 Parameter TO_CYCLES, 16, maximum cycles to wait for TX_BUSY to rise after a load.
REQ-004 Port CLK  in  1  single clock, the read-side clock of the async FIFO.
REQ-005 Port RST  in  1  reset, asynchronous, active-low.
REQ-006 Port EN  in  1  drain enable; when low, no new frame is started.
REQ-007 Port GAP_CFG  in  GAP_WIDTH  idle cycles inserted after each frame completes.
REQ-008 Port FIFO_EMPTY  in  1  FIFO empty flag, already synchronous to CLK.
REQ-009 Port FIFO_RD_DATA  in  DATA_WIDTH  FIFO head word, valid whenever FIFO_EMPTY is low.
REQ-010 Port FIFO_R_INC  out  1  one-cycle pop strobe to the FIFO.
REQ-011 Port TX_BUSY  in  1  UART transmitter busy.
REQ-012 Port TX_P_DATA  out  DATA_WIDTH  registered byte presented to the UART TX.
REQ-013 Port TX_DATA_VALID  out  1  one-cycle load strobe to the UART TX.
REQ-014 Port ERR_CLR  in  1  clears TO_ERR.
REQ-015 Port TO_ERR  out  1  sticky timeout flag.
REQ-016 Port FRAME_CNT  out  8  count of frames completed, wraps 255 -> 0.

Function
REQ-017 FSM states are IDLE, LOAD_WAIT, TX_WAIT and GAP, with IDLE as the reset state.
REQ-018 In IDLE, when EN=1, FIFO_EMPTY=0 and TX_BUSY=0 in the same cycle, the block SHALL register FIFO_RD_DATA into TX_P_DATA and pulse FIFO_R_INC and TX_DATA_VALID high for exactly that cycle, then go to LOAD_WAIT.
REQ-019 FIFO_R_INC and TX_DATA_VALID SHALL be high only in the IDLE-exit cycle of REQ-018, and always together: no pop without a load, and no load without a pop.
REQ-020 TX_P_DATA SHALL hold its value from the load cycle until the next load.
REQ-021 In LOAD_WAIT, TX_BUSY=1 SHALL cause a transition to TX_WAIT and clear the timeout counter.
REQ-022 In LOAD_WAIT, if TX_BUSY stays low for TO_CYCLES consecutive cycles, the block SHALL set TO_ERR and go to IDLE; FRAME_CNT SHALL NOT increment.
REQ-023 In TX_WAIT, TX_BUSY=0 SHALL increment FRAME_CNT and go to GAP if GAP_CFG != 0, otherwise to IDLE.
REQ-024 GAP SHALL last exactly GAP_CFG cycles, with GAP_CFG sampled on entry to GAP, and then return to IDLE.
REQ-025 EN falling mid-frame SHALL NOT abort the frame; EN is only checked in IDLE.
REQ-026 ERR_CLR=1 SHALL clear TO_ERR, except in a cycle where a new timeout sets it, in which case set wins.
REQ-027 Throughput is one byte per frame with a minimum of one IDLE cycle between frames; back-to-back frames SHALL be started without extra delay beyond GAP.
REQ-028 FIFO_EMPTY=1 in IDLE SHALL keep the block in IDLE with no strobes.

Reset
REQ-029 While RST=0, the block SHALL be in IDLE with FIFO_R_INC=0, TX_DATA_VALID=0, TX_P_DATA=0, TO_ERR=0, FRAME_CNT=0, and the gap and timeout counters at 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame immediately with no strobe emitted; after release, operation restarts from IDLE.

Structure
REQ-031 The FSM state encoding and the default TO_CYCLES value SHALL live in a shared UART system package.
REQ-032 The block is a single module with no sub-modules; the gap counter and timeout counter MAY share one down-counter of width max(GAP_WIDTH, clog2(TO_CYCLES+1)).

Verification
REQ-033 Preload FIFO with 0xA5, EN=1, TX_BUSY=0, model TX busy 10 cycles after load -> one TX_DATA_VALID/FIFO_R_INC pulse with TX_P_DATA=0xA5, FRAME_CNT=1.
REQ-034 Preload 3 bytes 0x01, 0x02, 0x03 with GAP_CFG=3 -> three loads in order, each load at least 3 cycles plus 1 IDLE cycle after the previous TX_BUSY fall, FRAME_CNT=3, FIFO_EMPTY=1 at end.
REQ-035 TX model never asserts TX_BUSY, TO_CYCLES=16 -> TO_ERR=1 exactly 16 cycles after the load, FSM in IDLE, FRAME_CNT unchanged; ERR_CLR pulse -> TO_ERR=0.
REQ-036 EN=0 with a non-empty FIFO -> no strobes for 50 cycles; EN=1 -> load on the next cycle.
REQ-037 Assert RST during TX_WAIT -> all outputs at reset values asynchronously; after release, the remaining FIFO data is drained normally.
REQ-038 Run 256 frames -> FRAME_CNT wraps to 0.
